// File: rtl/spk_det_cmp.sv
// spk_det_cmp: multi-lane spike threshold-crossing detector.
// Per-channel falling-edge flags, per-lane slots, round-robin event output.
module spk_det_cmp #(
  parameter int BITWIDTH = 32,
  parameter int BANK_NUM = 5,
  parameter int DEPTH    = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mua_valid,
  input  logic [BANK_NUM*BITWIDTH-1:0] mua_comb,
  input  logic [BANK_NUM*12-1:0]       ch_comb,
  input  logic [BANK_NUM*BITWIDTH-1:0] thr_comb,
  input  logic [BANK_NUM*BITWIDTH-1:0] off_set_comb,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [11:0]                  evt_ch,
  output logic [2:0]                   evt_lane,
  output logic [BITWIDTH-1:0]          evt_val,
  output logic                         ovf,
  output logic [15:0]                  drop_cnt,
  input  logic                         clr_ovf
);

  localparam int CW = 12;
  localparam int LW = 3;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = BITWIDTH + 1;
  localparam logic [BITWIDTH-1:0] SMAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] SMIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  logic                         a_valid;
  logic [BANK_NUM*BITWIDTH-1:0] a_mua;
  logic [BANK_NUM*CW-1:0]       a_ch;

  logic [BITWIDTH-1:0] smp_k [BANK_NUM];
  logic [BITWIDTH-1:0] off_k [BANK_NUM];
  logic [BITWIDTH-1:0] thr_k [BANK_NUM];
  logic [DW-1:0]       diff  [BANK_NUM];
  logic [BITWIDTH-1:0] sat_v [BANK_NUM];
  logic [CW-1:0]       ch_k  [BANK_NUM];
  logic [AW-1:0]       idx   [BANK_NUM];
  logic [BANK_NUM-1:0] below;
  logic [BANK_NUM-1:0] in_rng;
  logic [BANK_NUM-1:0] hit;

  logic [DEPTH-1:0] prev_below;

  logic [BANK_NUM-1:0] slot_full;
  logic [CW-1:0]       slot_ch  [BANK_NUM];
  logic [BITWIDTH-1:0] slot_val [BANK_NUM];

  logic [LW-1:0]       rr_ptr;
  int                  arb_j;
  logic                gnt_any;
  logic [LW-1:0]       gnt_lane;
  logic [CW-1:0]       gnt_ch;
  logic [BITWIDTH-1:0] gnt_val;
  logic                ld;
  logic [BANK_NUM-1:0] gnt;
  logic [BANK_NUM-1:0] drop;
  logic [16:0]         cnt_base;
  logic [16:0]         cnt_sum;
  logic [15:0]         cnt_next;

  // Stage A: align samples/channels with the threshold BRAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_mua   <= '0;
      a_ch    <= '0;
    end else begin
      a_valid <= mua_valid;
      a_mua   <= mua_comb;
      a_ch    <= ch_comb;
    end
  end

  // Per-lane offset correction, threshold compare, edge detect, clamp
  always_comb begin
    for (int k = 0; k < BANK_NUM; k++) begin
      smp_k[k]  = a_mua[k*BITWIDTH +: BITWIDTH];
      off_k[k]  = off_set_comb[k*BITWIDTH +: BITWIDTH];
      thr_k[k]  = thr_comb[k*BITWIDTH +: BITWIDTH];
      diff[k]   = {smp_k[k][BITWIDTH-1], smp_k[k]}
                - {off_k[k][BITWIDTH-1], off_k[k]};
      below[k]  = $signed(diff[k])
                < $signed({thr_k[k][BITWIDTH-1], thr_k[k]});
      ch_k[k]   = a_ch[k*CW +: CW];
      idx[k]    = AW'(ch_k[k]);
      in_rng[k] = (int'(ch_k[k]) < DEPTH);
      hit[k]    = a_valid & in_rng[k] & below[k]
                & ~prev_below[idx[k]];
      if (diff[k][DW-1] != diff[k][DW-2])
        sat_v[k] = diff[k][DW-1] ? SMIN : SMAX;
      else
        sat_v[k] = diff[k][BITWIDTH-1:0];
    end
  end

  // Channel flags; lanes evaluate the pre-frame flag, last lane wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_below <= '0;
    end else if (a_valid) begin
      for (int k = 0; k < BANK_NUM; k++)
        if (in_rng[k])
          prev_below[idx[k]] <= below[k];
    end
  end

  // Round-robin pick of the first full slot from rr_ptr
  always_comb begin
    arb_j    = 0;
    gnt_any  = 1'b0;
    gnt_lane = '0;
    gnt_ch   = '0;
    gnt_val  = '0;
    for (int i = 0; i < BANK_NUM; i++) begin
      arb_j = int'(rr_ptr) + i;
      if (arb_j >= BANK_NUM)
        arb_j = arb_j - BANK_NUM;
      if (!gnt_any && slot_full[arb_j]) begin
        gnt_any  = 1'b1;
        gnt_lane = LW'(arb_j);
        gnt_ch   = slot_ch[arb_j];
        gnt_val  = slot_val[arb_j];
      end
    end
  end

  // Grant, drop detection and saturating drop count
  always_comb begin
    ld       = ~evt_valid | evt_ready;
    gnt      = (ld && gnt_any) ? (BANK_NUM'(1) << gnt_lane) : '0;
    drop     = hit & slot_full & ~gnt;
    cnt_base = clr_ovf ? 17'd0 : {1'b0, drop_cnt};
    cnt_sum  = cnt_base + 17'($countones(drop));
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Lane slots: a granted slot empties but may refill the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full <= '0;
      for (int k = 0; k < BANK_NUM; k++) begin
        slot_ch[k]  <= '0;
        slot_val[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BANK_NUM; k++) begin
        if (gnt[k])
          slot_full[k] <= 1'b0;
        if (hit[k] && (!slot_full[k] || gnt[k])) begin
          slot_full[k] <= 1'b1;
          slot_ch[k]   <= ch_k[k];
          slot_val[k]  <= sat_v[k];
        end
      end
    end
  end

  // Output register with hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_lane  <= '0;
      evt_val   <= '0;
      rr_ptr    <= '0;
    end else if (ld) begin
      if (gnt_any) begin
        evt_valid <= 1'b1;
        evt_ch    <= gnt_ch;
        evt_lane  <= gnt_lane;
        evt_val   <= gnt_val;
        if (gnt_lane == LW'(BANK_NUM-1))
          rr_ptr <= '0;
        else
          rr_ptr <= gnt_lane + 1'b1;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a clear coinciding with drops keeps them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (clr_ovf)
        ovf <= |drop;
      else if (|drop)
        ovf <= 1'b1;
      drop_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_spk_det_cmp.sv
// tb_spk_det_cmp: scoreboard bench for spk_det_cmp.
// Expected events are queued at stimulus time and popped on handshake.
module tb_spk_det_cmp;

  logic         clk = 1'b0;
  logic         rst;
  logic         mua_valid;
  logic [159:0] mua_comb;
  logic [59:0]  ch_comb;
  logic [159:0] thr_comb;
  logic [159:0] off_set_comb;
  logic         evt_valid;
  logic         evt_ready;
  logic [11:0]  evt_ch;
  logic [2:0]   evt_lane;
  logic [31:0]  evt_val;
  logic         ovf;
  logic [15:0]  drop_cnt;
  logic         clr_ovf;

  spk_det_cmp dut (
    .clk(clk), .rst(rst), .mua_valid(mua_valid),
    .mua_comb(mua_comb), .ch_comb(ch_comb),
    .thr_comb(thr_comb), .off_set_comb(off_set_comb),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_lane(evt_lane), .evt_val(evt_val),
    .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ch;
    logic [2:0]  lane;
    logic [31:0] val;
  } ev_t;

  ev_t    sb[$];
  ev_t    mon_e;
  ev_t    head;
  int     n_chk = 0;
  int     n_pass = 0;
  int     n_got = 0;
  int     got0;
  int     thr_mem[4096];
  int     off_mem[4096];
  bit     mprev[256];
  int     fs[5];
  int     fc[5];
  bit     mb[5];
  bit     mh[5];
  longint md[5];
  longint sv;

  // Threshold BRAM: one cycle read latency from ch_comb
  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      thr_comb[k*32 +: 32]     <= thr_mem[ch_comb[k*12 +: 12]];
      off_set_comb[k*32 +: 32] <= off_mem[ch_comb[k*12 +: 12]];
    end
  end

  // Scoreboard: compare every accepted event against the queue head
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_chk++;
      n_got++;
      if (sb.size() == 0) begin
        $display("FAIL evt_unexpected: got ch=%0d lane=%0d val=%0d, required none",
                 evt_ch, evt_lane, $signed(evt_val));
      end else begin
        mon_e = sb.pop_front();
        if ({evt_ch, evt_lane, evt_val} !== mon_e)
          $display("FAIL evt_data: got ch=%0d lane=%0d val=%0d, required ch=%0d lane=%0d val=%0d",
                   evt_ch, evt_lane, $signed(evt_val),
                   mon_e.ch, mon_e.lane, $signed(mon_e.val));
        else
          n_pass++;
      end
    end
  end

  task automatic clear_lanes();
    for (int k = 0; k < 5; k++) begin
      fs[k] = 0;
      fc[k] = 300 + k;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    mua_valid = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 256; c++) mprev[c] = 1'b0;
  endtask

  // Drive one frame for one cycle and update the reference model
  task automatic frame(input bit push, input bit clr);
    for (int k = 0; k < 5; k++) begin
      mua_comb[k*32 +: 32] = fs[k];
      ch_comb[k*12 +: 12]  = 12'(fc[k]);
      mb[k] = 1'b0;
      mh[k] = 1'b0;
      md[k] = 0;
      if (fc[k] < 256) begin
        md[k] = longint'(fs[k]) - longint'(off_mem[fc[k]]);
        mb[k] = md[k] < longint'(thr_mem[fc[k]]);
        mh[k] = mb[k] && !mprev[fc[k]];
      end
    end
    for (int k = 0; k < 5; k++)
      if (fc[k] < 256) mprev[fc[k]] = mb[k];
    if (push)
      for (int k = 0; k < 5; k++)
        if (mh[k]) begin
          sv = md[k];
          if (sv > 64'sd2147483647) sv = 64'sd2147483647;
          if (sv < -64'sd2147483648) sv = -64'sd2147483648;
          sb.push_back('{ch: 12'(fc[k]), lane: 3'(k), val: 32'(sv)});
        end
    mua_valid = 1'b1;
    @(posedge clk); #1;
    mua_valid = 1'b0;
    clr_ovf = clr;
  endtask

  task automatic idle(input int n);
    mua_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; clr_ovf = 1'b0; end
  endtask

  task automatic wait_valid(input string nm);
    int i = 0;
    while (!evt_valid && i < 20) begin @(negedge clk); i++; end
    n_chk++;
    if (!evt_valid)
      $display("FAIL %s: evt_valid got 0 required 1 within 20 cycles", nm);
    else
      n_pass++;
  endtask

  task automatic drain(input string nm);
    int i = 0;
    while ((sb.size() != 0 || evt_valid) && i < 60) begin
      @(negedge clk); i++;
    end
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL %s: pending events got %0d required 0", nm, sb.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", evt_valid); else n_pass++;
    n_chk++; if (evt_ch !== 12'd0) $display("FAIL rst_ch: got %0d required 0", evt_ch); else n_pass++;
    n_chk++; if (evt_lane !== 3'd0) $display("FAIL rst_lane: got %0d required 0", evt_lane); else n_pass++;
    n_chk++; if (evt_val !== 32'd0) $display("FAIL rst_val: got %0d required 0", evt_val); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b required 0", ovf); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d required 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_single();
    reset_dut();
    evt_ready = 1'b1;
    got0 = n_got;
    clear_lanes();
    fc[0] = 5;
    fs[0] = -50;  frame(1, 0);
    fs[0] = -200; frame(1, 0);
    fs[0] = -300; frame(1, 0);
    mua_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL single_t2: evt_valid got %b required 0", evt_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (evt_valid !== 1'b1) $display("FAIL single_t3: evt_valid got %b required 1", evt_valid); else n_pass++;
    idle(2);
    drain("single_drain");
    n_chk++; if (n_got - got0 !== 1) $display("FAIL single_count: got %0d required 1", n_got - got0); else n_pass++;
  endtask

  task automatic test_rearm();
    reset_dut();
    evt_ready = 1'b1;
    got0 = n_got;
    clear_lanes();
    fc[0] = 5;
    fs[0] = -200; frame(1, 0);
    fs[0] = 0;    frame(1, 0);
    fs[0] = -200; frame(1, 0);
    fc[0] = 6;
    repeat (3) frame(1, 0);
    idle(2);
    drain("rearm_drain");
    n_chk++; if (n_got - got0 !== 3) $display("FAIL rearm_count: got %0d required 3", n_got - got0); else n_pass++;
  endtask

  task automatic test_round_robin();
    reset_dut();
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin fc[k] = 10 + k; fs[k] = -200; end
    frame(1, 0);
    wait_valid("rr_wait");
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (evt_valid !== 1'b1 || evt_lane !== 3'(i))
        $display("FAIL rr_order: got valid=%b lane=%0d required valid=1 lane=%0d", evt_valid, evt_lane, i);
      else
        n_pass++;
      @(negedge clk);
    end
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rr_end: evt_valid got %b required 0", evt_valid); else n_pass++;
    drain("rr_drain1");
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) fc[k] = 20 + k;
    frame(1, 0);
    wait_valid("bp_wait");
    head = sb[0];
    repeat (3) begin
      n_chk++;
      if (evt_valid !== 1'b1 || {evt_ch, evt_lane, evt_val} !== head)
        $display("FAIL bp_hold: got ch=%0d lane=%0d valid=%b required ch=%0d lane=%0d valid=1",
                 evt_ch, evt_lane, evt_valid, head.ch, head.lane);
      else
        n_pass++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    evt_ready = 1'b1;
    drain("bp_drain");
  endtask

  task automatic test_overflow();
    reset_dut();
    evt_ready = 1'b0;
    clear_lanes();
    fs[2] = -200;
    fc[2] = 30; frame(1, 0);
    fc[2] = 31; frame(1, 0);
    fc[2] = 32; frame(0, 0);
    idle(3);
    @(negedge clk);
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b required 1", ovf); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd1) $display("FAIL ovf_cnt: got %0d required 1", drop_cnt); else n_pass++;
    n_chk++; if (evt_ch !== 12'd30) $display("FAIL ovf_keep: got ch=%0d required 30", evt_ch); else n_pass++;
    fc[2] = 33; frame(0, 1);
    idle(3);
    @(negedge clk);
    n_chk++; if (ovf !== 1'b1) $display("FAIL clr_coinc_ovf: got %b required 1", ovf); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd1) $display("FAIL clr_coinc_cnt: got %0d required 1", drop_cnt); else n_pass++;
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    idle(2);
    @(negedge clk);
    n_chk++; if (ovf !== 1'b0) $display("FAIL clr_ovf: got %b required 0", ovf); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL clr_cnt: got %0d required 0", drop_cnt); else n_pass++;
    @(posedge clk); #1;
    evt_ready = 1'b1;
    drain("ovf_drain");
  endtask

  task automatic test_boundary();
    reset_dut();
    evt_ready = 1'b1;
    got0 = n_got;
    off_mem[9] = 1;
    clear_lanes();
    fc[0] = 9;   fs[0] = 32'h8000_0000;
    fc[1] = 7;   fs[1] = -200;
    fc[2] = 300; fs[2] = -200;
    fc[3] = 7;   fs[3] = -200;
    fc[4] = 301; fs[4] = -200;
    frame(1, 0);
    idle(2);
    drain("bnd_drain");
    n_chk++; if (n_got - got0 !== 3) $display("FAIL bnd_count: got %0d required 3", n_got - got0); else n_pass++;
    off_mem[9] = 10;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    evt_ready = 1'b0;
    clear_lanes();
    for (int k = 0; k < 4; k++) begin fc[k] = 40 + k; fs[k] = -200; end
    frame(0, 0);
    idle(4);
    for (int k = 0; k < 4; k++) fc[k] = 50 + k;
    frame(0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", evt_valid); else n_pass++;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 256; c++) mprev[c] = 1'b0;
    evt_ready = 1'b1;
    got0 = n_got;
    idle(10);
    n_chk++; if (n_got - got0 !== 0) $display("FAIL mid_stale: got %0d events required 0", n_got - got0); else n_pass++;
    clear_lanes();
    fc[0] = 40; fs[0] = -200;
    frame(1, 0);
    idle(2);
    drain("mid_drain");
    n_chk++; if (n_got - got0 !== 1) $display("FAIL mid_next: got %0d events required 1", n_got - got0); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 4096; c++) begin
      thr_mem[c] = -100;
      off_mem[c] = 10;
    end
    rst = 1'b1;
    mua_valid = 1'b0;
    mua_comb = '0;
    ch_comb = '0;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_rearm();
    test_round_robin();
    test_overflow();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
